// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a three-digit common-anode
// seven-segment display fed by BCD hundreds/tens/ones digits.
//
// Ports:
//   clk       system clock, rising-edge active
//   rst_n     asynchronous active-low reset
//   load      capture strobe for hundreds/tens/ones
//   hundreds  BCD hundreds digit
//   tens      BCD tens digit
//   ones      BCD ones digit
//   seg       segments {g,f,e,d,c,b,a}, active-low, registered
//   an        digit enables (an[0]=ones .. an[2]=hundreds), active-low, registered
//   frame     one-cycle pulse after the hundreds -> ones transition
//
// Optional build macro: SEVEN_SEG_LZ_BLANK_EN enables leading-zero blanking
// of the hundreds and tens digits.

module seven_seg_scanner #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       frame
);

   localparam int unsigned      DIV_W    = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [6:0]       SEG_BLANK = 7'h7F;
   localparam logic [2:0]       AN_OFF    = 3'b111;

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       idx;
   logic [3:0]       hold_h;
   logic [3:0]       hold_t;
   logic [3:0]       hold_o;
   logic             guard;

   logic             tick_c;
   logic [3:0]       digit_c;
   logic             blank_c;
   logic [6:0]       code_c;

   // Active-low segment pattern for one digit; non-decimal values show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'h40;
         4'd1:    c = 7'h79;
         4'd2:    c = 7'h24;
         4'd3:    c = 7'h30;
         4'd4:    c = 7'h19;
         4'd5:    c = 7'h12;
         4'd6:    c = 7'h02;
         4'd7:    c = 7'h78;
         4'd8:    c = 7'h00;
         4'd9:    c = 7'h10;
         default: c = 7'h3F;
      endcase
      return c;
   endfunction

   assign tick_c = (div_cnt == DIV_LAST);

   // Select the digit for the current scan slot and decide whether it is blanked.
   always_comb begin
      digit_c = 4'd0;
      blank_c = 1'b0;
      case (idx)
         2'd0: digit_c = hold_o;
         2'd1: begin
            digit_c = hold_t;
`ifdef SEVEN_SEG_LZ_BLANK_EN
            blank_c = (hold_h == 4'd0) && (hold_t == 4'd0);
`endif
         end
         2'd2: begin
            digit_c = hold_h;
`ifdef SEVEN_SEG_LZ_BLANK_EN
            blank_c = (hold_h == 4'd0);
`endif
         end
         default: blank_c = 1'b1;   // unreachable slot stays dark
      endcase
      code_c = seg_decode(digit_c);
   end

   // Holding register, prescaler, scan index and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         idx     <= 2'd0;
         hold_h  <= 4'd0;
         hold_t  <= 4'd0;
         hold_o  <= 4'd0;
         guard   <= 1'b0;
         frame   <= 1'b0;
         seg     <= SEG_BLANK;
         an      <= AN_OFF;
      end else begin
         if (load) begin
            hold_h <= hundreds;
            hold_t <= tens;
            hold_o <= ones;
         end

         div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);

         if (tick_c) begin
            idx <= (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
         end

         // guard darkens the anodes for the cycle following a slot change
         guard <= tick_c;
         frame <= tick_c && (idx == 2'd2);

         seg <= blank_c ? SEG_BLANK : code_c;
         an  <= (blank_c || guard) ? AN_OFF : ~(3'b001 << idx);
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: self-checking bench for seven_seg_scanner with
// REFRESH_DIV=4. A timeline model derives every output from the number of
// clock edges since reset release; directed literal checks pin that model.

module tb_seven_seg_scanner;

   localparam int R = 4;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [6:0] seg;
   logic [2:0] an;
   logic       frame;

   int n_checks;
   int n_fail;

   // model state
   int         e_cnt;
   logic [3:0] mh, mt, mo;
   logic [6:0] exp_seg;
   logic [2:0] exp_an;
   logic       exp_frame;

   seven_seg_scanner #(.REFRESH_DIV(R)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .seg      (seg),
      .an       (an),
      .frame    (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] code_of(input logic [3:0] d);
      logic [6:0] tab [0:9];
      tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      if (d > 4'd9) return 7'h3F;
      return tab[d];
   endfunction

   function automatic bit blanked(input int slot, input logic [3:0] h, input logic [3:0] t);
`ifdef SEVEN_SEG_LZ_BLANK_EN
      return (slot == 2 && h == 4'd0) || (slot == 1 && h == 4'd0 && t == 4'd0);
`else
      return 1'b0;
`endif
   endfunction

   // Timeline model: edge number p (0-based since release) fixes slot, guard, frame.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_cnt     <= 0;
         mh        <= 4'd0;
         mt        <= 4'd0;
         mo        <= 4'd0;
         exp_seg   <= 7'h7F;
         exp_an    <= 3'b111;
         exp_frame <= 1'b0;
      end else begin
         int p, slot;
         bit g, b;
         logic [3:0] d;
         p    = e_cnt;
         slot = (p / R) % 3;
         g    = (p >= R) && (p % R == 0);
         b    = blanked(slot, mh, mt);
         d    = (slot == 0) ? mo : (slot == 1) ? mt : mh;
         exp_seg   <= b ? 7'h7F : code_of(d);
         exp_an    <= (b || g) ? 3'b111 : ~(3'b001 << slot);
         exp_frame <= (p % R == R - 1) && (slot == 2);
         e_cnt     <= e_cnt + 1;
         if (load) begin
            mh <= hundreds;
            mt <= tens;
            mo <= ones;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      check("seg_model",   {1'b0, seg},      {1'b0, exp_seg});
      check("an_model",    {5'b0, an},       {5'b0, exp_an});
      check("frame_model", {7'b0, frame},    {7'b0, exp_frame});
   end

   task automatic wait_edge(input int target);
      while (e_cnt < target) @(negedge clk);
   endtask

   task automatic put(input bit l, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      load = l; hundreds = h; tens = t; ones = o;
   endtask

   function automatic logic [3:0] rnd_digit();
      if ($urandom_range(2) == 0) return 4'd0;
      return 4'($urandom_range(15));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int frames;
      bit found;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      put(0, 0, 0, 0);

      // reset held for 5 cycles
      repeat (5) begin
         @(negedge clk);
         check("rst_seg",   {1'b0, seg},   8'h7F);
         check("rst_an",    {5'b0, an},    8'h07);
         check("rst_frame", {7'b0, frame}, 8'h00);
      end
      rst_n = 1'b1;

      wait_edge(1);
      check("first_seg", {1'b0, seg}, 8'h40);
      check("first_an",  {5'b0, an},  8'h06);

      // 255 loaded at edge 2
      put(1, 4'd2, 4'd5, 4'd5);
      wait_edge(2);
      put(0, 4'd0, 4'd0, 4'd0);
      wait_edge(3);  check("l255_ones_seg", {1'b0, seg}, 8'h12); check("l255_ones_an", {5'b0, an}, 8'h06);
      wait_edge(5);  check("l255_guard_an", {5'b0, an}, 8'h07);  check("l255_guard_seg", {1'b0, seg}, 8'h12);
      wait_edge(6);  check("l255_tens_seg", {1'b0, seg}, 8'h12); check("l255_tens_an", {5'b0, an}, 8'h05);
      wait_edge(9);  check("l255_guard2_an", {5'b0, an}, 8'h07);
      wait_edge(10); check("l255_hund_seg", {1'b0, seg}, 8'h24); check("l255_hund_an", {5'b0, an}, 8'h03);
      wait_edge(11); check("frame_low", {7'b0, frame}, 8'h00);
      wait_edge(12); check("frame_high", {7'b0, frame}, 8'h01);
      frames = 0;
      repeat (24) begin
         @(negedge clk);
         if (frame) frames++;
      end
      check("frame_count_24", 8'(frames), 8'd2);

      // 007 loaded at edge 37
      wait_edge(36);
      put(1, 4'd0, 4'd0, 4'd7);
      wait_edge(37);
      put(0, 4'd0, 4'd0, 4'd0);
      wait_edge(38); check("l007_ones_seg", {1'b0, seg}, 8'h78); check("l007_ones_an", {5'b0, an}, 8'h06);
`ifdef SEVEN_SEG_LZ_BLANK_EN
      wait_edge(42); check("l007_tens_seg", {1'b0, seg}, 8'h7F); check("l007_tens_an", {5'b0, an}, 8'h07);
      wait_edge(46); check("l007_hund_seg", {1'b0, seg}, 8'h7F); check("l007_hund_an", {5'b0, an}, 8'h07);
`else
      wait_edge(42); check("l007_tens_seg", {1'b0, seg}, 8'h40); check("l007_tens_an", {5'b0, an}, 8'h05);
      wait_edge(46); check("l007_hund_seg", {1'b0, seg}, 8'h40); check("l007_hund_an", {5'b0, an}, 8'h03);
`endif

      // invalid tens digit
      wait_edge(48);
      put(1, 4'd1, 4'hC, 4'd3);
      wait_edge(49);
      put(0, 4'd0, 4'd0, 4'd0);
      wait_edge(54); check("dash_seg", {1'b0, seg}, 8'h3F); check("dash_an", {5'b0, an}, 8'h05);

      // load on the tick edge (edge 60 has div_cnt=3)
      wait_edge(59);
      put(1, 4'd9, 4'd9, 4'd9);
      wait_edge(60);
      put(0, 4'd0, 4'd0, 4'd0);
      wait_edge(61); check("coinc_seg", {1'b0, seg}, 8'h10); check("coinc_an", {5'b0, an}, 8'h07);
      wait_edge(62); check("coinc_seg2", {1'b0, seg}, 8'h10); check("coinc_an2", {5'b0, an}, 8'h06);

      // randomized loads
      repeat (300) begin
         put($urandom_range(3) == 0, rnd_digit(), rnd_digit(), rnd_digit());
         @(negedge clk);
      end
      // held load, inputs changing every cycle
      repeat (30) begin
         put(1, rnd_digit(), rnd_digit(), rnd_digit());
         @(negedge clk);
      end
      put(1, 4'd4, 4'd8, 4'd6);
      @(negedge clk);
      put(0, 4'd0, 4'd0, 4'd0);

      // mid-scan reset while the hundreds digit is enabled
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (exp_an == 3'b011) found = 1'b1;
      end
      check("midscan_found", {7'b0, found}, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      check("async_seg",   {1'b0, seg},   8'h7F);
      check("async_an",    {5'b0, an},    8'h07);
      check("async_frame", {7'b0, frame}, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_seg", {1'b0, seg}, 8'h40);
      check("restart_an",  {5'b0, an},  8'h06);

      repeat (100) begin
         put($urandom_range(3) == 0, rnd_digit(), rnd_digit(), rnd_digit());
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
